// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Bus-writable eight-digit seven-segment display driver. A single-cycle-ack
// slave interface exposes two registers: DATA (eight hex nibbles, digit k =
// DATA[4k+3:4k]) and CTRL (per-digit enable mask, bits 7:0). A prescaler
// dwells SCAN_DIV cycles on each digit and drives the shared active-low
// segment lines plus one active-low anode strobe per digit.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (2..2^20)
//
// Ports:
//   CLK_I   system clock, rising edge
//   RST_I   asynchronous active-high reset
//   STB_I   bus strobe
//   WE_I    1 = write, 0 = read
//   ADR_I   0 = DATA, 1 = CTRL
//   SEL_I   byte-lane enables for writes
//   DAT_I   write data
//   DAT_O   read data (registered, held between reads)
//   ACK_O   one-cycle acknowledge pulse
//   SEG_O   active-low segments {dp,g,f,e,d,c,b,a}
//   AN_O    active-low digit strobes, bit k = digit k
//
// Build option:
//   SEG7_READBACK_EN  when defined, reads return DATA/CTRL; when undefined the
//                     read-data register is removed and DAT_O is tied to 0
//                     (reads are still acknowledged with the same timing).
// -----------------------------------------------------------------------------
module seg7_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic        ADR_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic [7:0]  SEG_O,
    output logic [7:0]  AN_O
);

    localparam int unsigned   PW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    // Hex digit to active-low gfedcba pattern.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h40;
            4'h1:    pat = 7'h79;
            4'h2:    pat = 7'h24;
            4'h3:    pat = 7'h30;
            4'h4:    pat = 7'h19;
            4'h5:    pat = 7'h12;
            4'h6:    pat = 7'h02;
            4'h7:    pat = 7'h78;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h10;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h03;
            4'hC:    pat = 7'h46;
            4'hD:    pat = 7'h21;
            4'hE:    pat = 7'h06;
            4'hF:    pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    logic          r_ack;
    logic [31:0]   r_data;
    logic [7:0]    r_ctrl;
    logic [PW-1:0] r_presc;
    logic [2:0]    r_idx;
    logic [7:0]    r_seg;
    logic [7:0]    r_an;

    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_presc_wrap;
    logic [3:0]    w_nib;
    logic          w_dig_en;

    // Transaction qualifiers, slot wrap and current digit lookup.
    always_comb begin
        w_wr_en      = STB_I & WE_I & ~r_ack;
        w_rd_en      = STB_I & ~WE_I & ~r_ack;
        w_presc_wrap = (r_presc == PRESC_LAST);
        w_nib        = r_data[{r_idx, 2'b00} +: 4];
        w_dig_en     = r_ctrl[r_idx];
    end

    // Acknowledge: a held strobe acks every second cycle.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= STB_I & ~r_ack;
        end
    end

    // Register writes with byte-lane enables; CTRL only has lane 0.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_data <= 32'h0000_0000;
            r_ctrl <= 8'hFF;
        end else if (w_wr_en) begin
            if (ADR_I == 1'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (SEL_I[b]) begin
                        r_data[8*b +: 8] <= DAT_I[8*b +: 8];
                    end
                end
            end else if (SEL_I[0]) begin
                r_ctrl <= DAT_I[7:0];
            end
        end
    end

`ifdef SEG7_READBACK_EN
    logic [31:0] r_dat;

    // Read data captured on the acking edge, held otherwise.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_dat <= 32'h0000_0000;
        end else if (w_rd_en) begin
            r_dat <= ADR_I ? {24'h00_0000, r_ctrl} : r_data;
        end
    end

    assign DAT_O = r_dat;
`else
    // Readback removed: read strobes still get acked, data is always zero.
    assign DAT_O = 32'h0000_0000;
`endif

    // Prescaler and digit index; the index advances when the prescaler wraps.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_idx   <= r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Output words rebuilt every cycle from the current index, so anode and
    // segment values always come from the same index and register snapshot.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else if (w_dig_en) begin
            r_an  <= ~(8'b0000_0001 << r_idx);
            r_seg <= {1'b1, hex7(w_nib)};
        end else begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end
    end

    assign ACK_O = r_ack;
    assign SEG_O = r_seg;
    assign AN_O  = r_an;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
// Scoreboard bench for seg7_scan with SCAN_DIV = 4. Stimulus pushes expected
// bus responses (ack edge + read data) and expected scan outputs at specific
// clock edges into queues; a monitor sampling 1 time unit after each rising
// edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

    localparam int unsigned DIV = 4;
`ifdef SEG7_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stb;
    logic        we;
    logic        adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic [7:0]  seg;
    logic [7:0]  an;

    seg7_scan #(.SCAN_DIV(DIV)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .STB_I (stb),
        .WE_I  (we),
        .ADR_I (adr),
        .SEL_I (sel),
        .DAT_I (dat_i),
        .DAT_O (dat_o),
        .ACK_O (ack),
        .SEG_O (seg),
        .AN_O  (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        int          kind;     // 0 = AN_O, 1 = SEG_O, 2 = ACK_O
        logic [31:0] exp;
    } tchk_t;

    typedef struct {
        int          edge_n;
        bit          is_rd;
        logic [31:0] exp;
    } bus_t;

    tchk_t tq[$];
    bus_t  bq[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    n      = 0;   // rising edges since reset release

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Edge counter, cleared by reset like the DUT's scan state.
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // Monitor: timed output checks and ack-driven bus checks.
    always begin
        tchk_t t;
        bus_t  b;
        @(posedge clk);
        #1;
        while (tq.size() > 0 && tq[0].edge_n <= n) begin
            t = tq.pop_front();
            if (t.edge_n < n) begin
                check("missed_edge", n, t.edge_n);
            end else begin
                case (t.kind)
                    0:       check("an", {24'h0, an}, t.exp);
                    1:       check("seg", {24'h0, seg}, t.exp);
                    default: check("ack", {31'h0, ack}, t.exp);
                endcase
            end
        end
        if (ack === 1'b1) begin
            if (bq.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                b = bq.pop_front();
                check("ack_edge", n, b.edge_n);
                if (b.is_rd) check("rd_data", dat_o, b.exp);
            end
        end
    end

    function automatic int slot_start(input int d, input int from);
        for (int m = from; m < from + 40; m++) begin
            if ((((m - 1) / DIV) % 8) == d && ((m - 1) % DIV) == 0) return m;
        end
        return from;
    endfunction

    task automatic push_scan(input int m, input logic [7:0] a, input logic [7:0] s);
        tq.push_back('{m, 0, {24'h0, a}});
        tq.push_back('{m, 1, {24'h0, s}});
    endtask

    task automatic wait_until(input int m);
        int guard = 0;
        while (n < m && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // One bus transaction, entered and left on a falling edge.
    task automatic bus_xfer(input bit w, input bit a, input logic [3:0] s,
                            input logic [31:0] d, input logic [31:0] exp_rd);
        bq.push_back('{n + 1, !w, exp_rd});
        stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        @(negedge clk);
        stb = 1'b0; we = 1'b0; adr = 1'b0; sel = 4'h0; dat_i = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        int s;
        logic [7:0] ea;
        logic [7:0] es;
        rst = 1'b1; stb = 1'b0; we = 1'b0; adr = 1'b0; sel = 4'h0; dat_i = 32'h0;

        // Reset values, sampled while reset is held.
        tq.push_back('{0, 0, 32'h0000_00FF});
        tq.push_back('{0, 1, 32'h0000_00FF});
        tq.push_back('{0, 2, 32'h0000_0000});
        @(negedge clk);
        check("rst_dat", dat_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Default scan: one full frame plus the wrap back to digit 0.
        for (int m = 1; m <= 36; m++) begin
            push_scan(m, ~(8'b0000_0001 << (((m - 1) / DIV) % 8)), 8'hC0);
        end
        wait_until(36);

        // Full-word write then read-back; check digits 0 and 7.
        bus_xfer(1'b1, 1'b0, 4'hF, 32'hFEDC_BA98, 32'h0);
        bus_xfer(1'b0, 1'b0, 4'h0, 32'h0, RB ? 32'hFEDC_BA98 : 32'h0);
        s = slot_start(0, n + 2);
        push_scan(s, 8'hFE, 8'h80);
        push_scan(s + 7 * DIV, 8'h7F, 8'h8E);
        wait_until(s + 7 * DIV);

        // Byte-lane write into a cleared register.
        bus_xfer(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        bus_xfer(1'b1, 1'b0, 4'b0010, 32'h1111_1111, 32'h0);
        bus_xfer(1'b0, 1'b0, 4'h0, 32'h0, RB ? 32'h0000_1100 : 32'h0);
        s = slot_start(0, n + 2);
        push_scan(s, 8'hFE, 8'hC0);
        push_scan(s + 2 * DIV, 8'hFB, 8'hF9);
        wait_until(s + 2 * DIV);

        // CTRL = 05 (upper bytes of the write ignored): only digits 0 and 2.
        bus_xfer(1'b1, 1'b1, 4'hF, 32'hAABB_CC05, 32'h0);
        bus_xfer(1'b0, 1'b1, 4'h0, 32'h0, RB ? 32'h0000_0005 : 32'h0);
        s = slot_start(0, n + 2);
        for (int i = 0; i < 8 * DIV; i++) begin
            case (i / DIV)
                0:       begin ea = 8'hFE; es = 8'hC0; end
                2:       begin ea = 8'hFB; es = 8'hF9; end
                default: begin ea = 8'hFF; es = 8'hFF; end
            endcase
            push_scan(s + i, ea, es);
        end
        wait_until(s + 8 * DIV - 1);

        // Strobe held six cycles: acks on alternate edges, commits v0, v2, v4.
        s = n + 1;
        for (int k = 0; k < 6; k++) begin
            tq.push_back('{s + k, 2, (k % 2 == 0) ? 32'd1 : 32'd0});
        end
        bq.push_back('{s,     1'b0, 32'h0});
        bq.push_back('{s + 2, 1'b0, 32'h0});
        bq.push_back('{s + 4, 1'b0, 32'h0});
        stb = 1'b1; we = 1'b1; adr = 1'b0; sel = 4'hF;
        for (int k = 0; k < 6; k++) begin
            dat_i = 32'hA5A5_0000 + k;
            @(negedge clk);
        end
        stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0;
        @(negedge clk);
        bus_xfer(1'b0, 1'b0, 4'h0, 32'h0, RB ? 32'hA5A5_0004 : 32'h0);

        // Reset while ACK_O is high and the strobe is still asserted.
        bq.push_back('{n + 1, 1'b1, RB ? 32'hA5A5_0004 : 32'h0});
        stb = 1'b1; we = 1'b0; adr = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ack", {31'h0, ack}, 32'h0);
        check("arst_an", {24'h0, an}, 32'h0000_00FF);
        check("arst_seg", {24'h0, seg}, 32'h0000_00FF);
        check("arst_dat", dat_o, 32'h0);
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int m = 1; m <= DIV; m++) push_scan(m, 8'hFE, 8'hC0);
        push_scan(DIV + 1, 8'hFD, 8'hC0);
        bus_xfer(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        bus_xfer(1'b0, 1'b1, 4'h0, 32'h0, RB ? 32'h0000_00FF : 32'h0);
        wait_until(DIV + 2);
        @(negedge clk);

        check("tq_drained", tq.size(), 32'd0);
        check("bq_drained", bq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
